// File: rtl/rr_sched_pkg.sv
// Shared types, sizes and the rotating-priority pick used by the round-robin scheduler.
package rr_sched_pkg;

   localparam int NUM_REQ = 8;
   localparam int IDX_W   = 3;

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   // Returns the first requester with its bit set, scanning ptr, ptr+1, ... and wrapping.
   // The index arithmetic is IDX_W bits wide, so the wrap past 7 is free.
   // If no bit is set the result is ptr; callers only use it when req is non-zero.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req_vec,
                                                input logic [IDX_W-1:0]   ptr_val);
      logic [IDX_W-1:0] pick;
      logic [IDX_W-1:0] cand;
      pick = ptr_val;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         cand = ptr_val + IDX_W'(i);
         if (req_vec[cand]) begin
            pick = cand;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/grant_decoder.sv
// Enable-gated 3-to-8 one-hot decoder that turns the owner index into the grant vector.
module grant_decoder
   import rr_sched_pkg::*;
(
   input  logic [IDX_W-1:0]   idx,
   input  logic               en,
   output logic [NUM_REQ-1:0] oh
);

   // One bit per requester, all zero when no grant is held.
   always_comb begin
      oh = '0;
      if (en) begin
         oh[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin owner selection for an 8-way shared resource.
// A grant is held until done, until the owner drops its request,
// or until MAX_HOLD cycles have elapsed. Priority then rotates past the last owner.
module rr_grant_scheduler
   import rr_sched_pkg::*;
#(
   parameter int MAX_HOLD = 16
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               done,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_vld,
   output logic               timeout
);

   localparam int               CNT_W     = $clog2(MAX_HOLD);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_t           state;
   logic [IDX_W-1:0] ptr;
   logic [CNT_W-1:0] hold_cnt;
   logic             owner_req;
   logic             hold_expired;

   assign owner_req    = req[gnt_idx];
   assign hold_expired = (hold_cnt == HOLD_LAST);

   // Arbitration and grant lifetime: pick in IDLE, then release on done, request drop or hold limit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= '0;
         hold_cnt <= '0;
         gnt_idx  <= '0;
         gnt_vld  <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (|req) begin
                  gnt_idx  <= rr_pick(req, ptr);
                  gnt_vld  <= 1'b1;
                  hold_cnt <= '0;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               if (done || !owner_req || hold_expired) begin
                  ptr     <= gnt_idx + IDX_W'(1);
                  gnt_vld <= 1'b0;
                  state   <= IDLE;
                  timeout <= !done && owner_req;
               end else begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end
            default: begin
               state   <= IDLE;
               gnt_vld <= 1'b0;
            end
         endcase
      end
   end

   grant_decoder u_decoder (
      .idx (gnt_idx),
      .en  (gnt_vld),
      .oh  (gnt)
   );

   // The grant vector must be one-hot or empty and agree with gnt_vld.
   always_ff @(posedge clk) begin
      assert ($onehot0(gnt) && (gnt_vld == |gnt))
         else $error("grant vector not one-hot or disagrees with gnt_vld");
   end

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Scenario-driven bench for rr_grant_scheduler with a per-cycle expectation scoreboard.
module tb_rr_grant_scheduler;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_vld;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0] req;
      logic       done;
      logic       rst;
      logic       vld;
      logic [2:0] idx;
      logic       to;
   } vec_t;

   typedef struct packed {
      logic [7:0] gnt;
      logic [2:0] idx;
      logic       vld;
      logic       to;
   } obs_t;

   obs_t sb[$];

   rr_grant_scheduler #(.MAX_HOLD(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .done    (done),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld),
      .timeout (timeout)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Guard against a stuck run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mk(input logic [7:0] r, input logic d, input logic rs,
                               input logic v, input logic [2:0] i, input logic t);
      vec_t x;
      x.req = r; x.done = d; x.rst = rs; x.vld = v; x.idx = i; x.to = t;
      return x;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.gnt = gnt; o.idx = gnt_idx; o.vld = gnt_vld; o.to = timeout;
      return o;
   endfunction

   // Push the expected post-edge outputs, drive the inputs and advance past one rising edge.
   task automatic apply_stimulus(input vec_t v);
      obs_t e;
      e.vld = v.vld;
      e.idx = v.idx;
      e.to  = v.to;
      e.gnt = v.vld ? (8'h01 << v.idx) : 8'h00;
      sb.push_back(e);
      req  = v.req;
      done = v.done;
      rst  = v.rst;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      vec_t v[$];
      obs_t e, o;
      v.push_back(mk(8'hFF, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0));
      v.push_back(mk(8'hFF, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0));
      v.push_back(mk(8'hFF, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0));
      v.push_back(mk(8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0));
      v.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0));
      foreach (v[i]) begin
         apply_stimulus(v[i]);
         e = sb.pop_front();
         o = sample();
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL reset step %0d: got gnt=%h idx=%0d vld=%b to=%b, want gnt=%h idx=%0d vld=%b to=%b",
                     i, o.gnt, o.idx, o.vld, o.to, e.gnt, e.idx, e.vld, e.to);
         end
      end
   endtask

   task automatic test_done_release();
      vec_t v[$];
      obs_t e, o;
      v.push_back(mk(8'h20, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0));
      v.push_back(mk(8'h20, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0));
      v.push_back(mk(8'h20, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0));
      v.push_back(mk(8'h20, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0));
      v.push_back(mk(8'h20, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0));
      v.push_back(mk(8'h20, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0));
      v.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0));
      foreach (v[i]) begin
         apply_stimulus(v[i]);
         e = sb.pop_front();
         o = sample();
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL done_release step %0d: got gnt=%h idx=%0d vld=%b to=%b, want gnt=%h idx=%0d vld=%b to=%b",
                     i, o.gnt, o.idx, o.vld, o.to, e.gnt, e.idx, e.vld, e.to);
         end
      end
   endtask

   task automatic test_rotation();
      vec_t v[$];
      obs_t e, o;
      v.push_back(mk(8'hFF, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0));
      for (int k = 0; k <= 8; k++) begin
         v.push_back(mk(8'hFF, 1'b0, 1'b0, 1'b1, 3'(k % 8), 1'b0));
         v.push_back(mk(8'hFF, 1'b1, 1'b0, 1'b0, 3'(k % 8), 1'b0));
      end
      v.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0));
      foreach (v[i]) begin
         apply_stimulus(v[i]);
         e = sb.pop_front();
         o = sample();
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL rotation step %0d: got gnt=%h idx=%0d vld=%b to=%b, want gnt=%h idx=%0d vld=%b to=%b",
                     i, o.gnt, o.idx, o.vld, o.to, e.gnt, e.idx, e.vld, e.to);
         end
      end
   endtask

   task automatic test_timeout();
      vec_t v[$];
      obs_t e, o;
      for (int k = 0; k < 16; k++) begin
         v.push_back(mk(8'h08, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0));
      end
      v.push_back(mk(8'h08, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1));
      v.push_back(mk(8'h08, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0));
      v.push_back(mk(8'h08, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0));
      v.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0));
      foreach (v[i]) begin
         apply_stimulus(v[i]);
         e = sb.pop_front();
         o = sample();
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL timeout step %0d: got gnt=%h idx=%0d vld=%b to=%b, want gnt=%h idx=%0d vld=%b to=%b",
                     i, o.gnt, o.idx, o.vld, o.to, e.gnt, e.idx, e.vld, e.to);
         end
      end
   endtask

   task automatic test_req_drop();
      vec_t v[$];
      obs_t e, o;
      v.push_back(mk(8'h04, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0));
      v.push_back(mk(8'hFE, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0));
      v.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0));
      v.push_back(mk(8'h06, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0));
      v.push_back(mk(8'h06, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0));
      v.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0));
      foreach (v[i]) begin
         apply_stimulus(v[i]);
         e = sb.pop_front();
         o = sample();
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL req_drop step %0d: got gnt=%h idx=%0d vld=%b to=%b, want gnt=%h idx=%0d vld=%b to=%b",
                     i, o.gnt, o.idx, o.vld, o.to, e.gnt, e.idx, e.vld, e.to);
         end
      end
   endtask

   task automatic test_reset_mid_grant();
      vec_t v[$];
      obs_t e, o;
      for (int k = 0; k < 6; k++) begin
         v.push_back(mk(8'h10, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0));
      end
      v.push_back(mk(8'h10, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0));
      v.push_back(mk(8'hFF, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0));
      v.push_back(mk(8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0));
      foreach (v[i]) begin
         apply_stimulus(v[i]);
         e = sb.pop_front();
         o = sample();
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL reset_mid_grant step %0d: got gnt=%h idx=%0d vld=%b to=%b, want gnt=%h idx=%0d vld=%b to=%b",
                     i, o.gnt, o.idx, o.vld, o.to, e.gnt, e.idx, e.vld, e.to);
         end
      end
   endtask

   task automatic test_done_timeout_coincide();
      vec_t v[$];
      obs_t e, o;
      for (int k = 0; k < 16; k++) begin
         v.push_back(mk(8'h02, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0));
      end
      v.push_back(mk(8'h02, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0));
      v.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0));
      foreach (v[i]) begin
         apply_stimulus(v[i]);
         e = sb.pop_front();
         o = sample();
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL done_timeout step %0d: got gnt=%h idx=%0d vld=%b to=%b, want gnt=%h idx=%0d vld=%b to=%b",
                     i, o.gnt, o.idx, o.vld, o.to, e.gnt, e.idx, e.vld, e.to);
         end
      end
   endtask

   // Scenario sequence; each scenario leaves the priority pointer where the next one expects it.
   initial begin
      rst  = 1'b1;
      req  = 8'hFF;
      done = 1'b0;
      test_reset();
      test_done_release();
      test_rotation();
      test_timeout();
      test_req_drop();
      test_reset_mid_grant();
      test_done_timeout_coincide();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_grant_scheduler.md
Name: rr_grant_scheduler

Overview:
- Round-robin arbiter that shares one 8-way resource (an output channel driven by a 3-to-8 select decoder) among 8 requesters.
- Picks one requester, holds the grant until release or timeout, then rotates priority.
- Drives a binary grant index plus a one-hot grant vector, produced by an internal enable-gated 3-to-8 decoder.
- Sits between requesters and the shared resource's select/enable inputs.

Parameters:
- NUM_REQ, 8, number of requesters; fixed at 8 in this revision.
- IDX_W, 3, grant index width; equals log2(NUM_REQ).
- MAX_HOLD, 16, maximum consecutive cycles one grant is held; legal range 2..256.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  per-requester request level; bit i = requester i.
- done  input  1  release pulse from the current owner; ignored when no grant is held.
- gnt  output  8  one-hot grant; all zero when no grant is held.
- gnt_idx  output  3  binary index of the owner; holds its last value when gnt_vld=0.
- gnt_vld  output  1  high while a grant is held.
- timeout  output  1  one-cycle pulse when a grant is revoked by the MAX_HOLD limit.

Behaviour:
- Reset (synchronous, active-high, sampled at rising edge):
  - state=IDLE, gnt=0, gnt_idx=0, gnt_vld=0, timeout=0.
  - Priority pointer ptr=0, hold counter=0.
- FSM has two states, IDLE and GRANT. All outputs are registered.
- IDLE:
  - If req!=0 at an edge, select the first set bit scanning ptr, ptr+1, … wrapping mod 8.
  - Load gnt_idx, set gnt_vld=1, clear the hold counter, go to GRANT.
  - The grant is visible the cycle after req is sampled, so latency = 1 cycle.
- GRANT:
  - gnt = decoder(gnt_idx, en=gnt_vld).
  - Hold counter increments each cycle in GRANT.
- Release conditions, evaluated at each edge in GRANT, in priority order:
  1. done=1.
  2. req[gnt_idx]=0.
  3. Hold counter = MAX_HOLD-1. Only this condition pulses timeout=1 for the next cycle.
- On release:
  - ptr = gnt_idx+1 mod 8 (7 wraps to 0).
  - gnt_vld=0, gnt=0, state=IDLE.
  - There is exactly one dead cycle with no grant before the next arbitration.
- A grant lasts at most MAX_HOLD cycles.
- Simultaneous events:
  - done together with the timeout condition counts as a done release, with no timeout pulse.
  - A new req on other bits while in GRANT is ignored until IDLE.
- Fairness:
  - A continuously requesting requester waits at most 7 grants before being served.
  - In the worst case it waits 7*(MAX_HOLD+1) cycles.
- rst asserted mid-grant drops gnt at the next edge and returns ptr to 0. No timeout pulse is generated.
- gnt is always one-hot or zero. Assertion: $onehot0(gnt), and gnt_vld == |gnt.

Decomposition:
- Shared package rr_sched_pkg holds:
  - State enum {IDLE, GRANT}.
  - Constants NUM_REQ=8, IDX_W=3.
  - The rotate-priority-pick function (index after rotate by ptr).
- One sub-module, grant_decoder: combinational 3-to-8 one-hot decoder with enable.
  - Inputs: idx[2:0], en. Output: oh[7:0].
  - Outputs all zero when en=0.
  - Instantiated once to form gnt from gnt_idx and gnt_vld.

Test Plan:
- Hold rst=1 for 2 cycles with req=8'hFF -> gnt=0, gnt_vld=0, timeout=0. After release, req=8'hFF at ptr=0 -> gnt=8'h01, gnt_idx=0, one cycle later.
- req=8'h20 only, done pulse after 3 cycles of grant -> gnt=8'h20 for 3 cycles, one dead cycle, then gnt=8'h20 again (ptr=6 wraps to requester 5).
- req=8'hFF constant, done pulsed on every grant's first cycle -> gnt_idx sequence 0,1,…,7,0 with one dead cycle between grants; check the 7→0 wrap.
- req=8'h08 held, done never asserted, MAX_HOLD=16 -> grant exactly 16 cycles, timeout=1 for one cycle, dead cycle, then re-grant to idx 3.
- Owner 2 drops req[2] while done=0 -> release next edge, no timeout pulse, ptr=3. Then req=8'h06 -> granted idx 1 (scan wraps 3..7,0,1).
- rst asserted mid-grant (idx 4, hold count 5), plus done and the timeout condition coinciding on a separate grant -> first: gnt=0, ptr=0 next edge; second: release with timeout=0.
